// File: rtl/traffic_light_monitor.sv
// traffic_light_monitor
//
// Watches the three sensed lamps of a traffic-light controller and tracks
// which phase the controller is in. It enforces the legal order
// GREEN -> YELLOW -> RED -> GREEN. It also checks that each phase lasts
// between MIN_PHASE and MAX_PHASE cycles.
// Any violation latches a sticky fault and a fault code. The fault and code
// hold until clear_fault is sampled high.
//
// Parameters
//   MIN_PHASE   : minimum legal phase length in cycles
//   MAX_PHASE   : maximum legal phase length in cycles (MIN_PHASE..255)
//
// Ports
//   clock       : in  - single clock, rising edge
//   reset_n     : in  - asynchronous active-low reset
//   red         : in  - sensed red lamp
//   yellow      : in  - sensed yellow lamp
//   green       : in  - sensed green lamp
//   clear_fault : in  - synchronous request to return to IDLE
//   phase       : out - 00 IDLE/FAULT, 01 GREEN, 10 YELLOW, 11 RED
//   fault       : out - sticky fault flag
//   fault_code  : out - 0 none, 1 MULTI, 2 DARK, 3 SEQ, 4 SHORT, 5 TIMEOUT
//   phase_done  : out - one-cycle pulse on each legal phase change
//   phase_len   : out - length of the last completed phase
//   cycle_count : out - number of completed RED->GREEN changes (wraps)

module traffic_light_monitor #(
   parameter int MIN_PHASE = 1,
   parameter int MAX_PHASE = 16
) (
   input  logic       clock,
   input  logic       reset_n,
   input  logic       red,
   input  logic       yellow,
   input  logic       green,
   input  logic       clear_fault,
   output logic [1:0] phase,
   output logic       fault,
   output logic [2:0] fault_code,
   output logic       phase_done,
   output logic [7:0] phase_len,
   output logic [7:0] cycle_count
);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_GREEN,
      ST_YELLOW,
      ST_RED,
      ST_FAULT
   } state_t;

   localparam logic [2:0] CODE_NONE    = 3'd0;
   localparam logic [2:0] CODE_MULTI   = 3'd1;
   localparam logic [2:0] CODE_DARK    = 3'd2;
   localparam logic [2:0] CODE_SEQ     = 3'd3;
   localparam logic [2:0] CODE_SHORT   = 3'd4;
   localparam logic [2:0] CODE_TIMEOUT = 3'd5;

   // A lamp held for its sample that brings the count up to MAX_PHASE is the
   // timeout point, so the comparison is against the count before that
   // sample (MAX_PHASE-1).
   localparam logic [7:0] MAX_LIMIT = 8'(MAX_PHASE - 1);
   localparam logic [7:0] MIN_LIMIT = 8'(MIN_PHASE);

   state_t     r_state;
   logic [7:0] r_cnt;
   logic [1:0] r_phase;
   logic       r_fault;
   logic [2:0] r_code;
   logic       r_done;
   logic [7:0] r_len;
   logic [7:0] r_cycles;

   state_t     w_stateNext;
   logic [7:0] w_cntNext;
   logic [1:0] w_phaseNext;
   logic       w_faultNext;
   logic [2:0] w_codeNext;
   logic       w_doneNext;
   logic [7:0] w_lenNext;
   logic [7:0] w_cyclesNext;

   logic       w_multi;
   logic       w_dark;
   logic       w_curLit;
   logic       w_nextLit;
   state_t     w_nextLamp;
   logic       w_raise;
   logic [2:0] w_raiseCode;

   assign w_multi = (red & yellow) | (red & green) | (yellow & green);
   assign w_dark  = ~(red | yellow | green);

   // Which lamp belongs to the current phase and which lamp is the legal
   // successor. Outside the lamp states, neither lamp is considered lit.
   always_comb begin
      w_curLit   = 1'b0;
      w_nextLit  = 1'b0;
      w_nextLamp = ST_IDLE;
      case (r_state)
         ST_GREEN: begin
            w_curLit   = green;
            w_nextLit  = yellow;
            w_nextLamp = ST_YELLOW;
         end
         ST_YELLOW: begin
            w_curLit   = yellow;
            w_nextLit  = red;
            w_nextLamp = ST_RED;
         end
         ST_RED: begin
            w_curLit   = red;
            w_nextLit  = green;
            w_nextLamp = ST_GREEN;
         end
         default: begin
            w_curLit   = 1'b0;
            w_nextLit  = 1'b0;
            w_nextLamp = ST_IDLE;
         end
      endcase
   end

   // Next-state and next-output logic. Fault checks are ordered by priority.
   // A detected fault is applied at the end through w_raise, so that every
   // fault type takes the same path into FAULT. clear_fault overrides
   // everything else in the same cycle.
   always_comb begin
      w_stateNext  = r_state;
      w_cntNext    = r_cnt;
      w_faultNext  = r_fault;
      w_codeNext   = r_code;
      w_doneNext   = 1'b0;
      w_lenNext    = r_len;
      w_cyclesNext = r_cycles;
      w_raise      = 1'b0;
      w_raiseCode  = CODE_NONE;

      if (clear_fault) begin
         w_stateNext = ST_IDLE;
         w_cntNext   = 8'd0;
         w_faultNext = 1'b0;
         w_codeNext  = CODE_NONE;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_multi) begin
                  w_raise     = 1'b1;
                  w_raiseCode = CODE_MULTI;
               end else if (green) begin
                  w_stateNext = ST_GREEN;
                  w_cntNext   = 8'd1;
               end else if (red | yellow) begin
                  w_raise     = 1'b1;
                  w_raiseCode = CODE_SEQ;
               end
            end
            ST_GREEN, ST_YELLOW, ST_RED: begin
               if (w_multi) begin
                  w_raise     = 1'b1;
                  w_raiseCode = CODE_MULTI;
               end else if (w_dark) begin
                  w_raise     = 1'b1;
                  w_raiseCode = CODE_DARK;
               end else if (w_curLit) begin
                  if (r_cnt >= MAX_LIMIT) begin
                     w_raise     = 1'b1;
                     w_raiseCode = CODE_TIMEOUT;
                  end else if (r_cnt != 8'hFF) begin
                     w_cntNext = r_cnt + 8'd1;
                  end
               end else if (w_nextLit) begin
                  if (r_cnt < MIN_LIMIT) begin
                     w_raise     = 1'b1;
                     w_raiseCode = CODE_SHORT;
                  end else begin
                     w_stateNext = w_nextLamp;
                     w_lenNext   = r_cnt;
                     w_doneNext  = 1'b1;
                     w_cntNext   = 8'd1;
                     if (r_state == ST_RED) begin
                        w_cyclesNext = r_cycles + 8'd1;
                     end
                  end
               end else begin
                  w_raise     = 1'b1;
                  w_raiseCode = CODE_SEQ;
               end
            end
            default: begin
               w_stateNext = ST_FAULT;
            end
         endcase

         if (w_raise) begin
            w_stateNext = ST_FAULT;
            w_cntNext   = 8'd0;
            w_faultNext = 1'b1;
            w_codeNext  = w_raiseCode;
         end
      end

      case (w_stateNext)
         ST_GREEN:  w_phaseNext = 2'b01;
         ST_YELLOW: w_phaseNext = 2'b10;
         ST_RED:    w_phaseNext = 2'b11;
         default:   w_phaseNext = 2'b00;
      endcase
   end

   // State and output registers. Reset clears all progress, including the
   // phase length and cycle statistics.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_state  <= ST_IDLE;
         r_cnt    <= 8'd0;
         r_phase  <= 2'b00;
         r_fault  <= 1'b0;
         r_code   <= CODE_NONE;
         r_done   <= 1'b0;
         r_len    <= 8'd0;
         r_cycles <= 8'd0;
      end else begin
         r_state  <= w_stateNext;
         r_cnt    <= w_cntNext;
         r_phase  <= w_phaseNext;
         r_fault  <= w_faultNext;
         r_code   <= w_codeNext;
         r_done   <= w_doneNext;
         r_len    <= w_lenNext;
         r_cycles <= w_cyclesNext;
      end
   end

   assign phase       = r_phase;
   assign fault       = r_fault;
   assign fault_code  = r_code;
   assign phase_done  = r_done;
   assign phase_len   = r_len;
   assign cycle_count = r_cycles;

endmodule

// File: tb/tb_traffic_light_monitor.sv
// tb_traffic_light_monitor
//
// Directed bench for traffic_light_monitor. Three instances share the same
// lamp stimulus:
//   u_dut   : default parameters (MIN_PHASE=1, MAX_PHASE=16)
//   u_short : MIN_PHASE=3, MAX_PHASE=4
//   u_long  : MIN_PHASE=1, MAX_PHASE=255
// Each test task checks only the instance whose parameters it exercises.

module tb_traffic_light_monitor;

   localparam logic [2:0] L_D = 3'b000;
   localparam logic [2:0] L_G = 3'b001;
   localparam logic [2:0] L_Y = 3'b010;
   localparam logic [2:0] L_R = 3'b100;

   logic clock;
   logic resetN;
   logic red;
   logic yellow;
   logic green;
   logic clearFault;

   logic [1:0] dutPhase;
   logic       dutFault;
   logic [2:0] dutCode;
   logic       dutDone;
   logic [7:0] dutLen;
   logic [7:0] dutCount;

   logic [1:0] shortPhase;
   logic       shortFault;
   logic [2:0] shortCode;
   logic       shortDone;
   logic [7:0] shortLen;
   logic [7:0] shortCount;

   logic [1:0] longPhase;
   logic       longFault;
   logic [2:0] longCode;
   logic       longDone;
   logic [7:0] longLen;
   logic [7:0] longCount;

   int cmpCount;
   int failCount;

   traffic_light_monitor u_dut (
      .clock(clock), .reset_n(resetN), .red(red), .yellow(yellow),
      .green(green), .clear_fault(clearFault), .phase(dutPhase),
      .fault(dutFault), .fault_code(dutCode), .phase_done(dutDone),
      .phase_len(dutLen), .cycle_count(dutCount)
   );

   traffic_light_monitor #(.MIN_PHASE(3), .MAX_PHASE(4)) u_short (
      .clock(clock), .reset_n(resetN), .red(red), .yellow(yellow),
      .green(green), .clear_fault(clearFault), .phase(shortPhase),
      .fault(shortFault), .fault_code(shortCode), .phase_done(shortDone),
      .phase_len(shortLen), .cycle_count(shortCount)
   );

   traffic_light_monitor #(.MIN_PHASE(1), .MAX_PHASE(255)) u_long (
      .clock(clock), .reset_n(resetN), .red(red), .yellow(yellow),
      .green(green), .clear_fault(clearFault), .phase(longPhase),
      .fault(longFault), .fault_code(longCode), .phase_done(longDone),
      .phase_len(longLen), .cycle_count(longCount)
   );

   // 10 ns clock
   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Drives one lamp pattern ({red,yellow,green}) plus clear_fault. It then
   // advances one clock and leaves time 1 ns past the edge for sampling.
   task automatic applyStimulus(input logic [2:0] lamps, input logic clr);
      red        = lamps[2];
      yellow     = lamps[1];
      green      = lamps[0];
      clearFault = clr;
      @(posedge clock);
      #1;
   endtask

   // Pulses reset across two edges and releases it away from the clock edge.
   task automatic doReset();
      red        = 1'b0;
      yellow     = 1'b0;
      green      = 1'b0;
      clearFault = 1'b0;
      resetN     = 1'b0;
      repeat (2) @(posedge clock);
      #1;
      resetN = 1'b1;
   endtask

   // Reset takes effect before any clock edge and holds while asserted.
   task automatic test_reset();
      resetN     = 1'b1;
      red        = 1'b0;
      yellow     = 1'b0;
      green      = 1'b0;
      clearFault = 1'b0;
      #2 resetN  = 1'b0;
      #1;
      cmpCount++; if (dutPhase !== 2'b00) begin failCount++; $display("[TB] FAIL reset_phase got %b want 00", dutPhase); end
      cmpCount++; if (dutFault !== 1'b0) begin failCount++; $display("[TB] FAIL reset_fault got %b want 0", dutFault); end
      cmpCount++; if (dutCode !== 3'd0) begin failCount++; $display("[TB] FAIL reset_code got %0d want 0", dutCode); end
      cmpCount++; if (dutDone !== 1'b0) begin failCount++; $display("[TB] FAIL reset_done got %b want 0", dutDone); end
      cmpCount++; if (dutLen !== 8'd0) begin failCount++; $display("[TB] FAIL reset_len got %0d want 0", dutLen); end
      cmpCount++; if (dutCount !== 8'd0) begin failCount++; $display("[TB] FAIL reset_count got %0d want 0", dutCount); end
      repeat (2) @(posedge clock);
      #1;
      cmpCount++; if (dutPhase !== 2'b00) begin failCount++; $display("[TB] FAIL reset_hold_phase got %b want 00", dutPhase); end
      resetN = 1'b1;
   endtask

   // Legal G/Y/R/G walk, a longer green phase, then a dark lamp fault and
   // its clearance.
   task automatic test_sequence();
      applyStimulus(L_D, 1'b0);
      cmpCount++; if (dutPhase !== 2'b00) begin failCount++; $display("[TB] FAIL seq_dark_phase got %b want 00", dutPhase); end
      applyStimulus(L_G, 1'b0);
      cmpCount++; if (dutPhase !== 2'b01) begin failCount++; $display("[TB] FAIL seq_g_phase got %b want 01", dutPhase); end
      cmpCount++; if (dutDone !== 1'b0) begin failCount++; $display("[TB] FAIL seq_g_done got %b want 0", dutDone); end
      applyStimulus(L_Y, 1'b0);
      cmpCount++; if (dutPhase !== 2'b10) begin failCount++; $display("[TB] FAIL seq_y_phase got %b want 10", dutPhase); end
      cmpCount++; if (dutDone !== 1'b1) begin failCount++; $display("[TB] FAIL seq_y_done got %b want 1", dutDone); end
      cmpCount++; if (dutLen !== 8'd1) begin failCount++; $display("[TB] FAIL seq_y_len got %0d want 1", dutLen); end
      applyStimulus(L_R, 1'b0);
      cmpCount++; if (dutPhase !== 2'b11) begin failCount++; $display("[TB] FAIL seq_r_phase got %b want 11", dutPhase); end
      cmpCount++; if (dutDone !== 1'b1) begin failCount++; $display("[TB] FAIL seq_r_done got %b want 1", dutDone); end
      cmpCount++; if (dutCount !== 8'd0) begin failCount++; $display("[TB] FAIL seq_r_count got %0d want 0", dutCount); end
      applyStimulus(L_G, 1'b0);
      cmpCount++; if (dutPhase !== 2'b01) begin failCount++; $display("[TB] FAIL seq_g2_phase got %b want 01", dutPhase); end
      cmpCount++; if (dutDone !== 1'b1) begin failCount++; $display("[TB] FAIL seq_g2_done got %b want 1", dutDone); end
      cmpCount++; if (dutLen !== 8'd1) begin failCount++; $display("[TB] FAIL seq_g2_len got %0d want 1", dutLen); end
      cmpCount++; if (dutCount !== 8'd1) begin failCount++; $display("[TB] FAIL seq_g2_count got %0d want 1", dutCount); end
      cmpCount++; if (dutFault !== 1'b0) begin failCount++; $display("[TB] FAIL seq_g2_fault got %b want 0", dutFault); end
      applyStimulus(L_G, 1'b0);
      cmpCount++; if (dutDone !== 1'b0) begin failCount++; $display("[TB] FAIL seq_hold_done got %b want 0", dutDone); end
      applyStimulus(L_G, 1'b0);
      applyStimulus(L_Y, 1'b0);
      cmpCount++; if (dutLen !== 8'd3) begin failCount++; $display("[TB] FAIL seq_len3 got %0d want 3", dutLen); end
      applyStimulus(L_D, 1'b0);
      cmpCount++; if (dutCode !== 3'd2) begin failCount++; $display("[TB] FAIL dark_code got %0d want 2", dutCode); end
      cmpCount++; if (dutFault !== 1'b1) begin failCount++; $display("[TB] FAIL dark_fault got %b want 1", dutFault); end
      cmpCount++; if (dutPhase !== 2'b00) begin failCount++; $display("[TB] FAIL dark_phase got %b want 00", dutPhase); end
      cmpCount++; if (dutDone !== 1'b0) begin failCount++; $display("[TB] FAIL dark_done got %b want 0", dutDone); end
      cmpCount++; if (dutLen !== 8'd3) begin failCount++; $display("[TB] FAIL dark_len got %0d want 3", dutLen); end
      applyStimulus(L_D, 1'b1);
      cmpCount++; if (dutFault !== 1'b0) begin failCount++; $display("[TB] FAIL dark_clr_fault got %b want 0", dutFault); end
      cmpCount++; if (dutCode !== 3'd0) begin failCount++; $display("[TB] FAIL dark_clr_code got %0d want 0", dutCode); end
      cmpCount++; if (dutCount !== 8'd1) begin failCount++; $display("[TB] FAIL dark_clr_count got %0d want 1", dutCount); end
   endtask

   // MULTI outranks SEQ, FAULT ignores lamps, clear preserves statistics.
   // An out-of-order single lamp raises SEQ.
   task automatic test_multi();
      applyStimulus(L_D, 1'b0);
      applyStimulus(L_G, 1'b0);
      applyStimulus(L_R | L_Y, 1'b0);
      cmpCount++; if (dutCode !== 3'd1) begin failCount++; $display("[TB] FAIL multi_code got %0d want 1", dutCode); end
      applyStimulus(L_G, 1'b0);
      cmpCount++; if (dutPhase !== 2'b00) begin failCount++; $display("[TB] FAIL multi_ignore_phase got %b want 00", dutPhase); end
      cmpCount++; if (dutCode !== 3'd1) begin failCount++; $display("[TB] FAIL multi_ignore_code got %0d want 1", dutCode); end
      applyStimulus(L_G, 1'b1);
      cmpCount++; if (dutFault !== 1'b0) begin failCount++; $display("[TB] FAIL multi_clr_fault got %b want 0", dutFault); end
      cmpCount++; if (dutPhase !== 2'b00) begin failCount++; $display("[TB] FAIL multi_clr_phase got %b want 00", dutPhase); end
      cmpCount++; if (dutCount !== 8'd1) begin failCount++; $display("[TB] FAIL multi_clr_count got %0d want 1", dutCount); end
      applyStimulus(L_G, 1'b0);
      applyStimulus(L_R, 1'b0);
      cmpCount++; if (dutCode !== 3'd3) begin failCount++; $display("[TB] FAIL seq_skip_code got %0d want 3", dutCode); end
      applyStimulus(L_D, 1'b1);
   endtask

   // MAX_PHASE=4 instance: timeout on the fourth green sample, then sticky.
   task automatic test_timeout();
      doReset();
      repeat (3) applyStimulus(L_G, 1'b0);
      cmpCount++; if (shortFault !== 1'b0) begin failCount++; $display("[TB] FAIL tmo_g3_fault got %b want 0", shortFault); end
      cmpCount++; if (shortPhase !== 2'b01) begin failCount++; $display("[TB] FAIL tmo_g3_phase got %b want 01", shortPhase); end
      applyStimulus(L_G, 1'b0);
      cmpCount++; if (shortCode !== 3'd5) begin failCount++; $display("[TB] FAIL tmo_code got %0d want 5", shortCode); end
      cmpCount++; if (shortPhase !== 2'b00) begin failCount++; $display("[TB] FAIL tmo_phase got %b want 00", shortPhase); end
      applyStimulus(L_G, 1'b0);
      applyStimulus(L_R, 1'b0);
      cmpCount++; if (shortCode !== 3'd5) begin failCount++; $display("[TB] FAIL tmo_sticky_code got %0d want 5", shortCode); end
      cmpCount++; if (shortFault !== 1'b1) begin failCount++; $display("[TB] FAIL tmo_sticky_fault got %b want 1", shortFault); end
      applyStimulus(L_D, 1'b1);
      cmpCount++; if (shortFault !== 1'b0) begin failCount++; $display("[TB] FAIL tmo_clr_fault got %b want 0", shortFault); end
   endtask

   // MIN_PHASE=3 instance: a 2-cycle green is SHORT, a 3-cycle green is
   // legal. A red lamp in IDLE is SEQ. The default instance accepts the
   // 2-cycle green.
   task automatic test_short();
      doReset();
      applyStimulus(L_G, 1'b0);
      applyStimulus(L_G, 1'b0);
      applyStimulus(L_Y, 1'b0);
      cmpCount++; if (shortCode !== 3'd4) begin failCount++; $display("[TB] FAIL short_code got %0d want 4", shortCode); end
      cmpCount++; if (shortDone !== 1'b0) begin failCount++; $display("[TB] FAIL short_done got %b want 0", shortDone); end
      cmpCount++; if (shortLen !== 8'd0) begin failCount++; $display("[TB] FAIL short_len got %0d want 0", shortLen); end
      cmpCount++; if (dutDone !== 1'b1) begin failCount++; $display("[TB] FAIL short_dflt_done got %b want 1", dutDone); end
      cmpCount++; if (dutLen !== 8'd2) begin failCount++; $display("[TB] FAIL short_dflt_len got %0d want 2", dutLen); end
      applyStimulus(L_R, 1'b1);
      applyStimulus(L_R, 1'b0);
      cmpCount++; if (shortCode !== 3'd3) begin failCount++; $display("[TB] FAIL idle_red_code got %0d want 3", shortCode); end
      applyStimulus(L_D, 1'b1);
      repeat (3) applyStimulus(L_G, 1'b0);
      applyStimulus(L_Y, 1'b0);
      cmpCount++; if (shortDone !== 1'b1) begin failCount++; $display("[TB] FAIL min_ok_done got %b want 1", shortDone); end
      cmpCount++; if (shortLen !== 8'd3) begin failCount++; $display("[TB] FAIL min_ok_len got %0d want 3", shortLen); end
   endtask

   // 256 full cycles wrap cycle_count. A long green then times out at 16 on
   // the default instance and at 255 on the MAX_PHASE=255 instance.
   task automatic test_wrap();
      doReset();
      applyStimulus(L_G, 1'b0);
      for (int i = 0; i < 256; i++) begin
         applyStimulus(L_Y, 1'b0);
         applyStimulus(L_R, 1'b0);
         applyStimulus(L_G, 1'b0);
         if (i == 254) begin
            cmpCount++; if (dutCount !== 8'd255) begin failCount++; $display("[TB] FAIL wrap_255 got %0d want 255", dutCount); end
         end
      end
      cmpCount++; if (dutCount !== 8'd0) begin failCount++; $display("[TB] FAIL wrap_0 got %0d want 0", dutCount); end
      cmpCount++; if (longCount !== 8'd0) begin failCount++; $display("[TB] FAIL wrap_long_0 got %0d want 0", longCount); end
      for (int k = 2; k <= 300; k++) begin
         applyStimulus(L_G, 1'b0);
         if (k == 15) begin
            cmpCount++; if (dutFault !== 1'b0) begin failCount++; $display("[TB] FAIL dflt_g15_fault got %b want 0", dutFault); end
         end
         if (k == 16) begin
            cmpCount++; if (dutCode !== 3'd5) begin failCount++; $display("[TB] FAIL dflt_g16_code got %0d want 5", dutCode); end
         end
         if (k == 254) begin
            cmpCount++; if (longFault !== 1'b0) begin failCount++; $display("[TB] FAIL long_g254_fault got %b want 0", longFault); end
            cmpCount++; if (longPhase !== 2'b01) begin failCount++; $display("[TB] FAIL long_g254_phase got %b want 01", longPhase); end
         end
         if (k == 255) begin
            cmpCount++; if (longCode !== 3'd5) begin failCount++; $display("[TB] FAIL long_g255_code got %0d want 5", longCode); end
         end
      end
      cmpCount++; if (longCode !== 3'd5) begin failCount++; $display("[TB] FAIL long_end_code got %0d want 5", longCode); end
      cmpCount++; if (longLen !== 8'd1) begin failCount++; $display("[TB] FAIL long_end_len got %0d want 1", longLen); end
      cmpCount++; if (longCount !== 8'd0) begin failCount++; $display("[TB] FAIL long_end_count got %0d want 0", longCount); end
   endtask

   // Reset asserted mid-YELLOW clears outputs without a clock edge. Yellow
   // seen first after release is SEQ.
   task automatic test_async_reset();
      doReset();
      applyStimulus(L_G, 1'b0);
      for (int i = 0; i < 5; i++) begin
         applyStimulus(L_Y, 1'b0);
         applyStimulus(L_R, 1'b0);
         applyStimulus(L_G, 1'b0);
      end
      applyStimulus(L_Y, 1'b0);
      cmpCount++; if (dutCount !== 8'd5) begin failCount++; $display("[TB] FAIL ar_pre_count got %0d want 5", dutCount); end
      cmpCount++; if (dutPhase !== 2'b10) begin failCount++; $display("[TB] FAIL ar_pre_phase got %b want 10", dutPhase); end
      #3 resetN = 1'b0;
      #1;
      cmpCount++; if (dutPhase !== 2'b00) begin failCount++; $display("[TB] FAIL ar_phase got %b want 00", dutPhase); end
      cmpCount++; if (dutCount !== 8'd0) begin failCount++; $display("[TB] FAIL ar_count got %0d want 0", dutCount); end
      cmpCount++; if (dutLen !== 8'd0) begin failCount++; $display("[TB] FAIL ar_len got %0d want 0", dutLen); end
      cmpCount++; if (dutDone !== 1'b0) begin failCount++; $display("[TB] FAIL ar_done got %b want 0", dutDone); end
      resetN = 1'b1;
      applyStimulus(L_Y, 1'b0);
      cmpCount++; if (dutCode !== 3'd3) begin failCount++; $display("[TB] FAIL ar_seq_code got %0d want 3", dutCode); end
      cmpCount++; if (dutFault !== 1'b1) begin failCount++; $display("[TB] FAIL ar_seq_fault got %b want 1", dutFault); end
   endtask

   // Runs every scenario in order and prints the summary line.
   initial begin
      cmpCount  = 0;
      failCount = 0;
      test_reset();
      test_sequence();
      test_multi();
      test_timeout();
      test_short();
      test_wrap();
      test_async_reset();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmpCount, failCount);
      $finish;
   end

endmodule
